// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait sequencing, load-use bubbles, branch flush.
// Optional perf counters are built when STALL_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MISS_TIMEOUT = 200,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_Rt_i,
  input  logic [4:0]  IFID_Rs_i,
  input  logic [4:0]  IFID_Rt_i,
  input  logic        EXMEM_MemRead_i,
  input  logic        EXMEM_MemWrite_i,
  input  logic        dmem_ack_i,
  input  logic        branch_taken_i,
  output logic        dmem_req_o,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        idex_flush_o,
  output logic        exmem_stall_o,
  output logic        memwb_stall_o,
  output logic        ifid_flush_o,
  output logic        timeout_o,
  output logic [31:0] perf_mem_stall_o,
  output logic [31:0] perf_bubble_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MISS_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic             mem_acc_s, req_s, mem_stall_s, lu_s;

  assign mem_acc_s = EXMEM_MemRead_i | EXMEM_MemWrite_i;

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state plus request/memory-stall decode; an ack in the request cycle never stalls
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    req_s       = 1'b0;
    mem_stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_s       = mem_acc_s;
        mem_stall_s = mem_acc_s & ~dmem_ack_i;
        if (mem_acc_s && !dmem_ack_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        req_s       = 1'b1;
        mem_stall_s = ~dmem_ack_i;
        if (dmem_ack_i) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        mem_stall_s = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_stall_s = 1'b1;
      end
    endcase
  end

  // A frozen pipe needs no bubble, so load-use only counts when memory is not stalling
  assign lu_s = IDEX_MemRead_i & (IDEX_Rt_i != 5'd0) &
                ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i)) & ~mem_stall_s;

  assign dmem_req_o    = rst_i & req_s;
  assign pc_stall_o    = rst_i & (mem_stall_s | lu_s);
  assign ifid_stall_o  = rst_i & (mem_stall_s | lu_s);
  assign idex_flush_o  = rst_i & lu_s;
  assign exmem_stall_o = rst_i & mem_stall_s;
  assign memwb_stall_o = rst_i & mem_stall_s;
  assign ifid_flush_o  = rst_i & branch_taken_i & ~mem_stall_s & ~lu_s;
  assign timeout_o     = timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_mem_q, perf_bub_q;

  // Saturating stall and bubble counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_mem_q <= 32'd0;
      perf_bub_q <= 32'd0;
    end else begin
      if (mem_stall_s && (perf_mem_q != 32'hFFFF_FFFF)) begin
        perf_mem_q <= perf_mem_q + 32'd1;
      end
      if (lu_s && (perf_bub_q != 32'hFFFF_FFFF)) begin
        perf_bub_q <= perf_bub_q + 32'd1;
      end
    end
  end

  assign perf_mem_stall_o = perf_mem_q;
  assign perf_bubble_o    = perf_bub_q;
`else
  assign perf_mem_stall_o = 32'b0;
  assign perf_bubble_o    = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue of expected output vectors.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i;
  logic        EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_ack_i, branch_taken_i;
  logic        dmem_req_o, pc_stall_o, ifid_stall_o, idex_flush_o;
  logic        exmem_stall_o, memwb_stall_o, ifid_flush_o, timeout_o;
  logic [31:0] perf_mem_stall_o, perf_bubble_o;

  int checks = 0;
  int errors = 0;
  int exp_ms = 0;
  int exp_bb = 0;

  // {req, pc, ifid, idex_flush, exmem, memwb, ifid_flush, timeout}
  localparam logic [7:0] E_NONE  = 8'b0000_0000;
  localparam logic [7:0] E_MSTL  = 8'b1110_1100;
  localparam logic [7:0] E_ACK   = 8'b1000_0000;
  localparam logic [7:0] E_LU    = 8'b0111_0000;
  localparam logic [7:0] E_ACKLU = 8'b1111_0000;
  localparam logic [7:0] E_BR    = 8'b0000_0010;
  localparam logic [7:0] E_ERR   = 8'b0110_1101;

  logic [7:0] exp_q[$];

  pipe_hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_Rt_i(IDEX_Rt_i),
    .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
    .EXMEM_MemRead_i(EXMEM_MemRead_i), .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .dmem_ack_i(dmem_ack_i), .branch_taken_i(branch_taken_i),
    .dmem_req_o(dmem_req_o), .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o),
    .idex_flush_o(idex_flush_o), .exmem_stall_o(exmem_stall_o),
    .memwb_stall_o(memwb_stall_o), .ifid_flush_o(ifid_flush_o), .timeout_o(timeout_o),
    .perf_mem_stall_o(perf_mem_stall_o), .perf_bubble_o(perf_bubble_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic set_in(input logic ld_ex, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                        input logic [4:0] rt_id, input logic m_rd, input logic m_wr,
                        input logic ack, input logic br);
    IDEX_MemRead_i   = ld_ex;
    IDEX_Rt_i        = rt_ex;
    IFID_Rs_i        = rs_id;
    IFID_Rt_i        = rt_id;
    EXMEM_MemRead_i  = m_rd;
    EXMEM_MemWrite_i = m_wr;
    dmem_ack_i       = ack;
    branch_taken_i   = br;
  endtask

  task automatic compare_out(input string tag);
    logic [7:0]  obs, exp;
    logic [31:0] pm_exp, pb_exp;
    exp = exp_q.pop_front();
    obs = {dmem_req_o, pc_stall_o, ifid_stall_o, idex_flush_o,
           exmem_stall_o, memwb_stall_o, ifid_flush_o, timeout_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
    end
`ifdef STALL_PERF_CNT_EN
    pm_exp = 32'(exp_ms);
    pb_exp = 32'(exp_bb);
`else
    pm_exp = 32'd0;
    pb_exp = 32'd0;
`endif
    checks++;
    assert ({perf_mem_stall_o, perf_bubble_o} === {pm_exp, pb_exp}) else begin
      errors++;
      $error("FAIL %s_perf observed=%0d/%0d expected=%0d/%0d",
             tag, perf_mem_stall_o, perf_bubble_o, pm_exp, pb_exp);
    end
    if (exp[3]) exp_ms++;
    if (exp[4]) exp_bb++;
  endtask

  task automatic step(input logic ld_ex, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                      input logic [4:0] rt_id, input logic m_rd, input logic m_wr,
                      input logic ack, input logic br, input logic [7:0] exp, input string tag);
    @(posedge clk_i);
    #1;
    set_in(ld_ex, rt_ex, rs_id, rt_id, m_rd, m_wr, ack, br);
    exp_q.push_back(exp);
    @(negedge clk_i);
    compare_out(tag);
  endtask

  initial begin
    // Reset held with hazards on the inputs: everything must read 0
    rst_i = 1'b0;
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    exp_q.push_back(E_NONE);
    compare_out("reset_hold");
    exp_ms = 0;
    exp_bb = 0;
    @(negedge clk_i);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;

    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "idle");
    // Load acked in the request cycle, state must stay IDLE
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_ACK,  "load_ack_now");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "after_fast_ack");
    // Store with three stall cycles then ack
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MSTL, "store_s0");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MSTL, "store_s1");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MSTL, "store_s2");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_ACK,  "store_ack");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "store_idle");
    step(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, E_LU,   "lu_rs");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "perf_3_1");
    step(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_LU,   "lu_rt");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "lu_r0");
    step(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "no_load");
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_LU,   "lu_beats_br");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_BR,   "branch");
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_MSTL, "mstl_beats_lu");
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_ACKLU, "wait_ack_lu");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "back_idle");
    // Miss with no ack: request cycle, four MEM_WAIT cycles, then ERROR
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_MSTL, "to_req");
    for (int i = 0; i < 4; i++)
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_MSTL, $sformatf("to_wait%0d", i));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_ERR,  "err0");
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_ERR,  "err_hold");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_ERR,  "err_ack");
    // Asynchronous reset mid-stall clears outputs without a clock edge
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    exp_ms = 0;
    exp_bb = 0;
    exp_q.push_back(E_NONE);
    compare_out("async_rst");
    exp_ms = 0;
    exp_bb = 0;
    @(negedge clk_i);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "post_rst");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_MSTL, "post_rst_miss");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_ACK,  "post_rst_ack");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
